umips_div: RTL

UMIPS_DIV -- requirements
Module: umips_div

---
 rtl/umips_div.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/umips_div.sv
// Radix-2 restoring divider with a three-state IDLE/RUN/DONE sequencer.
// Define UMIPS_DIV_SIGNED_EN to add the sgn port and signed (truncating) division.
module umips_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
`ifdef UMIPS_DIV_SIGNED_EN
    input  logic        sgn,
`endif
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        busy,
    output logic        done,
    output logic        dbz
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] quo_w_q, quo_w_d;
    logic [31:0] rem_w_q, rem_w_d;
    logic [31:0] div_q, div_d;
    logic [31:0] quotient_q, quotient_d;
    logic [31:0] remainder_q, remainder_d;
    logic        dbz_q, dbz_d;

    logic [31:0] a_mag, b_mag;
    logic [32:0] rem_sh, diff;
    logic        step_ge;
    logic [31:0] step_quo, step_rem, fin_quo, fin_rem;

`ifdef UMIPS_DIV_SIGNED_EN
    logic negq_q, negq_d;
    logic negr_q, negr_d;
    logic a_neg, b_neg;

    always_comb begin
        a_neg = sgn & a[31];
        b_neg = sgn & b[31];
        a_mag = a_neg ? (~a + 32'd1) : a;
        b_mag = b_neg ? (~b + 32'd1) : b;
    end
`else
    always_comb begin
        a_mag = a;
        b_mag = b;
    end
`endif

    // One restoring step: shift the next dividend bit into the partial remainder
    // and keep the difference only when it does not borrow.
    always_comb begin
        rem_sh   = {rem_w_q, quo_w_q[31]};
        diff     = rem_sh - {1'b0, div_q};
        step_ge  = ~diff[32];
        step_rem = step_ge ? diff[31:0] : rem_sh[31:0];
        step_quo = {quo_w_q[30:0], step_ge};
        fin_quo  = step_quo;
        fin_rem  = step_rem;
`ifdef UMIPS_DIV_SIGNED_EN
        if (negq_q) fin_quo = ~step_quo + 32'd1;
        if (negr_q) fin_rem = ~step_rem + 32'd1;
`endif
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        quo_w_d     = quo_w_q;
        rem_w_d     = rem_w_q;
        div_d       = div_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
`ifdef UMIPS_DIV_SIGNED_EN
        negq_d      = negq_q;
        negr_d      = negr_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (b == 32'd0) begin
                        quotient_d  = 32'hFFFF_FFFF;
                        remainder_d = a;
                        dbz_d       = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        quo_w_d = a_mag;
                        rem_w_d = 32'd0;
                        div_d   = b_mag;
                        cnt_d   = 5'd0;
`ifdef UMIPS_DIV_SIGNED_EN
                        negq_d  = a_neg ^ b_neg;
                        negr_d  = a_neg;
`endif
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                quo_w_d = step_quo;
                rem_w_d = step_rem;
                cnt_d   = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    quotient_d  = fin_quo;
                    remainder_d = fin_rem;
                    dbz_d       = 1'b0;
                    state_d     = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 5'd0;
            quo_w_q     <= 32'd0;
            rem_w_q     <= 32'd0;
            div_q       <= 32'd0;
            quotient_q  <= 32'd0;
            remainder_q <= 32'd0;
            dbz_q       <= 1'b0;
`ifdef UMIPS_DIV_SIGNED_EN
            negq_q      <= 1'b0;
            negr_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            quo_w_q     <= quo_w_d;
            rem_w_q     <= rem_w_d;
            div_q       <= div_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
`ifdef UMIPS_DIV_SIGNED_EN
            negq_q      <= negq_d;
            negr_q      <= negr_d;
`endif
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign dbz       = dbz_q;
    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);

endmodule
